// File: rtl/mult4b_seq_if.sv
// mult4b_seq_if: start/done handshake bundle for the sequential 4x4 multiplier
//   start - request a multiplication (requester -> multiplier)
//   A, B  - 4-bit unsigned operands (requester -> multiplier)
//   busy  - multiplication in progress (multiplier -> requester)
//   done  - one-cycle pulse when P updates (multiplier -> requester)
//   P     - 8-bit unsigned product register (multiplier -> requester)
interface mult4b_seq_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] P;
    modport master (output start, A, B, input busy, done, P);
    modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/mult4b_seq.sv
// mult4b_seq: 4x4 unsigned shift-and-add multiplier, one product per 5 cycles
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - mult4b_seq_if.slave: start/A/B in, busy/done/P out
module sum4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic c1, c2, c3;
    assign Sum[0] = A[0] ^ B[0];
    assign c1     = A[0] & B[0];
    assign Sum[1] = A[1] ^ B[1] ^ c1;
    assign c2     = (A[1] & B[1]) | (c1 & (A[1] ^ B[1]));
    assign Sum[2] = A[2] ^ B[2] ^ c2;
    assign c3     = (A[2] & B[2]) | (c2 & (A[2] ^ B[2]));
    assign Sum[3] = A[3] ^ B[3] ^ c3;
    assign Cout   = (A[3] & B[3]) | (c3 & (A[3] ^ B[3]));
endmodule

module mult4b_seq (
    input logic         clk,
    input logic         rst,
    mult4b_seq_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t     state_q, state_d;
    logic [3:0] m_q, m_d, h_q, h_d, l_q, l_d;
    logic [1:0] cnt_q, cnt_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic [7:0] p_q, p_d;
    logic [3:0] sum;
    logic       cout;
    sum4b u_add (
        .A    (h_q),
        .B    (l_q[0] ? m_q : 4'b0),
        .Sum  (sum),
        .Cout (cout)
    );
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        h_d     = h_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        p_d     = p_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                m_d     = bus.A;
                l_d     = bus.B;
                h_d     = 4'h0;
                cnt_d   = 2'd0;
                state_d = RUN;
                busy_d  = 1'b1;
            end
        end else begin
            // shift the 5-bit partial sum right by one into {H,L}
            h_d   = {cout, sum[3:1]};
            l_d   = {sum[0], l_q[3:1]};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                p_d     = {cout, sum[3:1], sum[0], l_q[3:1]};
                done_d  = 1'b1;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= 4'h0;
            h_q     <= 4'h0;
            l_q     <= 4'h0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            h_q     <= h_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            p_q     <= p_d;
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.P    = p_q;
endmodule

// File: tb/tb_mult4b_seq.sv
// tb_mult4b_seq: directed and exhaustive checks of mult4b_seq against a product model
module tb_mult4b_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    mult4b_seq_if bus();
    mult4b_seq dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // model: an accepted request yields A*B exactly 4 edges later
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_p = 8'h00;
    int         m_left = 0;
    int         m_a = 0;
    int         m_b = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_p    = 8'h00;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_p    = 8'(m_a * m_b);
                end
            end else if (bus.start) begin
                m_busy = 1'b1;
                m_left = 4;
                m_a    = int'(bus.A);
                m_b    = int'(bus.B);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            chk("model_busy", 8'(bus.busy), 8'(m_busy));
            chk("model_done", 8'(bus.done), 8'(m_done));
            chk("model_P", bus.P, m_p);
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    task automatic go(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        go(a, b);
        chk("busy_t0", 8'(bus.busy), 8'd1);
        repeat (3) begin
            @(negedge clk);
            chk("busy_run", 8'(bus.busy), 8'd1);
            chk("done_early", 8'(bus.done), 8'd0);
        end
        @(negedge clk);
        chk("done_t4", 8'(bus.done), 8'd1);
        chk("busy_t4", 8'(bus.busy), 8'd0);
        chk("P_t4", bus.P, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.A = 4'h0;
        bus.B = 4'h0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_done", 8'(bus.done), 8'd0);
        chk("rst_P", bus.P, 8'h00);

        run(4'd0, 4'd0, 8'h00);
        @(negedge clk);
        chk("done_pulse_width", 8'(bus.done), 8'd0);

        run(4'd15, 4'd15, 8'hE1);

        // 13*11 then 7*1 with start held high throughout
        @(negedge clk);
        bus.A = 4'd13;
        bus.B = 4'd11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.A = 4'd7;
        bus.B = 4'd1;
        repeat (4) @(negedge clk);
        chk("b2b_done1", 8'(bus.done), 8'd1);
        chk("b2b_P1", bus.P, 8'd143);
        @(negedge clk);
        chk("b2b_busy2", 8'(bus.busy), 8'd1);
        chk("b2b_P_hold", bus.P, 8'd143);
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_done2", 8'(bus.done), 8'd1);
        chk("b2b_P2", bus.P, 8'd7);

        // start while busy is ignored
        go(4'd9, 4'd6);
        @(negedge clk);
        bus.A = 4'd3;
        bus.B = 4'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("ign_done", 8'(bus.done), 8'd1);
        chk("ign_P", bus.P, 8'd54);
        repeat (3) begin
            @(negedge clk);
            chk("ign_no_done", 8'(bus.done), 8'd0);
            chk("ign_no_busy", 8'(bus.busy), 8'd0);
        end

        // reset mid-run aborts silently
        run(4'd5, 4'd5, 8'd25);
        go(4'd12, 4'd12);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 8'(bus.busy), 8'd0);
        chk("abort_done", 8'(bus.done), 8'd0);
        chk("abort_P", bus.P, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_done", 8'(bus.done), 8'd0);
            chk("abort_P_hold", bus.P, 8'h00);
        end

        done_cnt = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run(4'(a), 4'(b), 8'(a * b));
        @(negedge clk);
        chk("sweep_done_count", 8'(done_cnt), 8'(256));
        checks++;
        if (done_cnt != 256) begin
            failures++;
            $display("FAIL sweep_done_total actual=%0d required=256", done_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
